// File: rtl/int_nest_ctrl.sv
// rtl/int_nest_ctrl.sv - nesting, programmable-priority interrupt controller with vectored req/ack
module int_nest_ctrl #(
    parameter int          NSRC       = 4,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0009,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0033,
    localparam int         IDW        = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int         LW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              CLR_n,
    input  logic              en,
    input  logic [NSRC-1:0]   irq,
    input  logic              int_ack,
    input  logic              eret,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              int_req,
    output logic [31:0]       int_vec,
    output logic [IDW-1:0]    cur_id,
    output logic              cur_valid,
    output logic [LW-1:0]     nest_level,
    output logic [NSRC-1:0]   pending
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t              r_state;
    logic [NSRC-1:0]     r_s1, r_s2, r_s3;
    logic [NSRC-1:0]     r_pend;
    logic [NSRC-1:0]     r_mask;
    logic [2*NSRC-1:0]   r_prio;
    logic                r_ie;
    logic [IDW-1:0]      r_stk_id  [DEPTH];
    logic [1:0]          r_stk_pri [DEPTH];
    logic [LW-1:0]       r_lvl;
    logic                r_req;
    logic [31:0]         r_vec;
    logic [IDW-1:0]      r_id;

    logic [NSRC-1:0]     w_cand, w_edge, w_clr;
    logic                w_found, w_empty, w_elig, w_ack, w_pop;
    logic [IDW-1:0]      w_win, w_top_id;
    logic [1:0]          w_win_pri, w_top_pri, w_push_pri;
    logic [SW-1:0]       w_top_idx;
    logic                w_unused;

    assign w_unused = ^cfg_wdata[31:2*NSRC];

    // Lowest PRIO value wins; strict compare keeps the lowest index on ties.
    always_comb begin
        w_cand    = r_pend & r_mask;
        w_found   = 1'b0;
        w_win     = '0;
        w_win_pri = 2'd3;
        for (int i = 0; i < NSRC; i++) begin
            if (w_cand[i] && (!w_found || r_prio[2*i +: 2] < w_win_pri)) begin
                w_found   = 1'b1;
                w_win     = IDW'(i);
                w_win_pri = r_prio[2*i +: 2];
            end
        end
    end

    assign w_empty    = (r_lvl == '0);
    assign w_top_idx  = SW'(r_lvl - LW'(1));
    assign w_top_id   = w_empty ? '0 : r_stk_id[w_top_idx];
    assign w_top_pri  = w_empty ? 2'd0 : r_stk_pri[w_top_idx];
    assign w_push_pri = r_prio[2*r_id +: 2];
    assign w_edge     = r_s2 & ~r_s3;
    assign w_ack      = en && (r_state == S_REQ) && int_ack;
    assign w_pop      = en && eret && !w_empty;
    assign w_elig     = r_ie && w_found && (r_lvl < LW'(DEPTH))
                        && (w_empty || (w_win_pri < w_top_pri));

    always_comb begin
        w_clr = '0;
        if (w_ack) w_clr[r_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            r_state <= S_IDLE;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_prio  <= '0;
            r_ie    <= 1'b0;
            r_lvl   <= '0;
            r_req   <= 1'b0;
            r_vec   <= '0;
            r_id    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stk_id[i]  <= '0;
                r_stk_pri[i] <= '0;
            end
        end else begin
            r_s1 <= irq;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            // A fresh edge wins over the clear-on-ack of the same bit.
            r_pend <= (r_pend & ~w_clr) | w_edge;

            if (en) begin
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd0:    r_mask <= cfg_wdata[NSRC-1:0];
                        2'd1:    r_prio <= cfg_wdata[2*NSRC-1:0];
                        default: ;
                    endcase
                end

                if (w_ack)
                    r_ie <= 1'b0;
                else if (w_pop)
                    r_ie <= 1'b1;
                else if (cfg_we && cfg_addr == 2'd2)
                    r_ie <= cfg_wdata[0];

                // Pop-then-push reuses the old top slot, leaving the level unchanged.
                if (w_ack && w_pop) begin
                    r_stk_id[w_top_idx]  <= r_id;
                    r_stk_pri[w_top_idx] <= w_push_pri;
                end else if (w_ack) begin
                    r_stk_id[SW'(r_lvl)]  <= r_id;
                    r_stk_pri[SW'(r_lvl)] <= w_push_pri;
                    r_lvl                 <= r_lvl + LW'(1);
                end else if (w_pop) begin
                    r_lvl <= r_lvl - LW'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_elig) begin
                            r_id    <= w_win;
                            r_vec   <= VEC_BASE + 32'(w_win) * VEC_STRIDE;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (int_ack) begin
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0:    cfg_rdata[NSRC-1:0]   = r_mask;
            2'd1:    cfg_rdata[2*NSRC-1:0] = r_prio;
            2'd2:    cfg_rdata[0]          = r_ie;
            default: begin
                cfg_rdata[8 +: LW]     = r_lvl;
                cfg_rdata[NSRC-1:0]    = r_pend;
            end
        endcase
    end

    assign int_req    = r_req;
    assign int_vec    = r_vec;
    assign cur_id     = w_top_id;
    assign cur_valid  = !w_empty;
    assign nest_level = r_lvl;
    assign pending    = r_pend;
endmodule

// File: tb/tb_int_nest_ctrl.sv
// tb/tb_int_nest_ctrl.sv - directed and randomized check of int_nest_ctrl against a behavioural model
module tb_int_nest_ctrl;
    localparam int        NSRC  = 4;
    localparam int        DEPTH = 4;
    localparam bit [31:0] VB    = 32'h0000_0009;
    localparam bit [31:0] VS    = 32'h0000_0033;

    logic            clk = 1'b0;
    logic            CLR_n, en, int_ack, eret, cfg_we;
    logic [NSRC-1:0] irq;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            int_req;
    logic [31:0]     int_vec;
    logic [1:0]      cur_id;
    logic            cur_valid;
    logic [2:0]      nest_level;
    logic [NSRC-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    int_nest_ctrl #(
        .NSRC(NSRC), .DEPTH(DEPTH), .VEC_BASE(VB), .VEC_STRIDE(VS)
    ) dut (
        .clk(clk), .CLR_n(CLR_n), .en(en), .irq(irq), .int_ack(int_ack), .eret(eret),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_req(int_req), .int_vec(int_vec), .cur_id(cur_id), .cur_valid(cur_valid),
        .nest_level(nest_level), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: service stack as a queue, irq history as a queue of samples.
    typedef struct { int id; int pri; } ent_t;
    ent_t            m_stk[$];
    bit [NSRC-1:0]   m_hist[$];
    bit [NSRC-1:0]   m_pend, m_mask;
    int              m_prio[NSRC];
    bit              m_ie, m_busy;
    int              m_id;
    bit [31:0]       m_vec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_rd(input bit [1:0] a);
        bit [31:0] r;
        r = 0;
        case (a)
            2'd0: r = 32'(m_mask);
            2'd1: for (int i = 0; i < NSRC; i++) r = r | (32'(m_prio[i]) << (2 * i));
            2'd2: r = 32'(m_ie);
            default: r = (32'(m_stk.size()) << 8) | 32'(m_pend);
        endcase
        return r;
    endfunction

    task automatic model_step();
        bit [NSRC-1:0] edg, clr;
        int            win, best;
        bit            ack, pop, elig;
        ent_t          e;
        if (!CLR_n) begin
            m_stk.delete();
            m_hist.delete();
            repeat (3) m_hist.push_back('0);
            m_pend = '0; m_mask = '0; m_ie = 0; m_busy = 0; m_id = 0; m_vec = 0;
            for (int i = 0; i < NSRC; i++) m_prio[i] = 0;
            return;
        end
        // pending rises two samples after irq is first seen high after a low sample
        edg = m_hist[1] & ~m_hist[2];
        clr = '0;
        if (en) begin
            ack  = m_busy && int_ack;
            pop  = eret && (m_stk.size() > 0);
            win  = -1;
            best = 4;
            for (int i = 0; i < NSRC; i++)
                if (m_pend[i] && m_mask[i] && m_prio[i] < best) begin
                    win = i; best = m_prio[i];
                end
            elig = !m_busy && m_ie && (win >= 0) && (m_stk.size() < DEPTH)
                   && (m_stk.size() == 0 || best < m_stk[$].pri);
            if (ack) begin
                clr[m_id] = 1'b1;
                e.id = m_id; e.pri = m_prio[m_id];
            end
            if (pop) void'(m_stk.pop_back());
            if (ack) begin m_stk.push_back(e); m_busy = 0; end
            if (elig) begin m_busy = 1; m_id = win; m_vec = VB + 32'(win) * VS; end
            if (ack) m_ie = 0;
            else if (pop) m_ie = 1;
            else if (cfg_we && cfg_addr == 2'd2) m_ie = cfg_wdata[0];
            if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[NSRC-1:0];
            if (cfg_we && cfg_addr == 2'd1)
                for (int i = 0; i < NSRC; i++) m_prio[i] = int'(cfg_wdata[2*i +: 2]);
        end
        m_pend = (m_pend & ~clr) | edg;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
    endtask

    task automatic compare_model();
        chk("int_req", 32'(int_req), 32'(m_busy));
        if (m_busy) chk("int_vec", int_vec, m_vec);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("nest_level", 32'(nest_level), 32'(m_stk.size()));
        chk("cur_valid", 32'(cur_valid), 32'(m_stk.size() != 0));
        chk("cur_id", 32'(cur_id), (m_stk.size() != 0) ? 32'(m_stk[$].id) : 32'd0);
        chk("cfg_rdata", cfg_rdata, m_rd(cfg_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic cfg_wr(input bit [1:0] a, input bit [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input int k);
        irq = NSRC'(1 << k);
        tick();
        irq = '0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input bit [1:0] a, input bit [31:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic wait_req(input int budget);
        for (int n = 0; n < budget && !int_req; n++) tick();
        chk("req_within_budget", 32'(int_req), 32'd1);
    endtask

    task automatic do_reset();
        CLR_n = 1'b0; tick(); tick(); CLR_n = 1'b1;
    endtask

    initial begin
        CLR_n = 1'b0; en = 1'b1; irq = '0; int_ack = 1'b0; eret = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        repeat (3) m_hist.push_back('0);

        do_reset();
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_int_vec", int_vec, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_nest", 32'(nest_level), 32'd0);
        chk("rst_cur_valid", 32'(cur_valid), 32'd0);
        rd_chk("rst_mask", 2'd0, 32'd0);

        // single source, latency E3/E4
        cfg_wr(2'd0, 32'hF);
        cfg_wr(2'd2, 32'h1);
        pulse(1);
        chk("e1_pending", 32'(pending), 32'd0);
        tick();
        chk("e2_pending", 32'(pending), 32'd0);
        tick();
        chk("e3_pending", 32'(pending), 32'h2);
        chk("e3_int_req", 32'(int_req), 32'd0);
        tick();
        chk("e4_int_req", 32'(int_req), 32'd1);
        chk("e4_int_vec", int_vec, 32'h3C);
        do_ack();
        chk("ack_int_req", 32'(int_req), 32'd0);
        chk("ack_pending", 32'(pending), 32'd0);
        chk("ack_nest", 32'(nest_level), 32'd1);
        chk("ack_cur_id", 32'(cur_id), 32'd1);
        rd_chk("ack_ie", 2'd2, 32'd0);
        do_eret();
        chk("eret_nest", 32'(nest_level), 32'd0);
        rd_chk("eret_ie", 2'd2, 32'd1);

        // priority: src2=0 beats src0=1 on the same edge
        cfg_wr(2'd1, 32'hCD);
        irq = 4'b0101; tick(); irq = '0;
        wait_req(8);
        chk("prio_first_vec", int_vec, 32'h6F);
        do_ack();
        do_eret();
        wait_req(4);
        chk("prio_second_vec", int_vec, 32'h09);
        do_ack();
        do_eret();

        // nesting: equal priority blocked, higher nests
        cfg_wr(2'd1, 32'hB6);
        pulse(3);
        wait_req(8);
        chk("nest_src3_vec", int_vec, 32'hA2);
        do_ack();
        cfg_wr(2'd2, 32'h1);
        pulse(0);
        repeat (6) tick();
        chk("equal_prio_blocked", 32'(int_req), 32'd0);
        chk("equal_prio_pending", 32'(pending), 32'h1);
        pulse(1);
        wait_req(8);
        chk("nested_vec", int_vec, 32'h3C);
        do_ack();
        chk("nested_level", 32'(nest_level), 32'd2);
        do_eret();
        repeat (3) tick();
        chk("still_blocked", 32'(int_req), 32'd0);
        chk("pop_cur_id", 32'(cur_id), 32'd3);
        do_eret();
        wait_req(4);
        chk("after_unwind_vec", int_vec, 32'h09);
        do_ack();
        do_eret();

        // depth limit: stored priority 3 at every level, candidates at 2
        do_reset();
        cfg_wr(2'd0, 32'hF);
        for (int k = 0; k < DEPTH; k++) begin
            cfg_wr(2'd1, 32'hAA);
            cfg_wr(2'd2, 32'h1);
            pulse(k);
            wait_req(8);
            cfg_wr(2'd1, 32'hFF);
            chk("req_held_prio_change", 32'(int_req), 32'd1);
            do_ack();
        end
        chk("full_nest", 32'(nest_level), 32'd4);
        cfg_wr(2'd1, 32'hAA);
        cfg_wr(2'd2, 32'h1);
        pulse(0);
        repeat (6) tick();
        chk("full_no_req", 32'(int_req), 32'd0);
        do_eret();
        chk("full_pop_nest", 32'(nest_level), 32'd3);
        wait_req(3);
        chk("full_pop_vec", int_vec, 32'h09);

        // en=0 stall, empty-stack eret, ack+eret, reset mid-request
        do_reset();
        cfg_wr(2'd0, 32'hF);
        cfg_wr(2'd1, 32'h10);
        cfg_wr(2'd2, 32'h1);
        en = 1'b0;
        pulse(2);
        repeat (9) tick();
        chk("stall_pending", 32'(pending), 32'h4);
        chk("stall_no_req", 32'(int_req), 32'd0);
        en = 1'b1;
        tick();
        chk("unstall_req", 32'(int_req), 32'd1);
        chk("unstall_vec", int_vec, 32'h6F);
        do_eret();
        chk("empty_eret_nest", 32'(nest_level), 32'd0);
        chk("empty_eret_req", 32'(int_req), 32'd1);
        rd_chk("empty_eret_ie", 2'd2, 32'd1);
        do_ack();
        cfg_wr(2'd2, 32'h1);
        pulse(1);
        wait_req(8);
        int_ack = 1'b1; eret = 1'b1; tick(); int_ack = 1'b0; eret = 1'b0;
        chk("swap_nest", 32'(nest_level), 32'd1);
        chk("swap_cur_id", 32'(cur_id), 32'd1);
        rd_chk("swap_ie", 2'd2, 32'd0);
        do_eret();
        pulse(0);
        wait_req(8);
        CLR_n = 1'b0; tick(); CLR_n = 1'b1;
        chk("clr_int_req", 32'(int_req), 32'd0);
        chk("clr_int_vec", int_vec, 32'd0);
        chk("clr_pending", 32'(pending), 32'd0);
        chk("clr_nest", 32'(nest_level), 32'd0);
        chk("clr_cur_valid", 32'(cur_valid), 32'd0);
        chk("clr_cur_id", 32'(cur_id), 32'd0);
        rd_chk("clr_mask", 2'd0, 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            CLR_n     = ($urandom_range(0, 499) != 0);
            en        = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NSRC; i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            int_ack   = ($urandom_range(0, 3) == 0);
            eret      = ($urandom_range(0, 11) == 0);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
            if (cfg_we && cfg_addr == 2'd2 && $urandom_range(0, 1) == 0) cfg_wdata[0] = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
